// File: rtl/playback_sequencer.sv
// playback_sequencer: steps through the first n colour segments, showing
// each one for a timer period followed by a dark period, then strobes done.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | one cycle: reload the flash timer with the speed for this round
// ON    | colour segment[index] is lit, waiting for the timer pulse
// OFF   | LEDs dark, waiting for the timer pulse
// DONE  | one-cycle completion strobe
module playback_sequencer #(
    parameter int MAX_SEG     = 33,
    parameter int SPEED_SHIFT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [5:0]               round,
    input  logic [MAX_SEG-1:0][1:0]  segment,
    input  logic                     pulse,
    output logic                     load_speed,
    output logic [2:0]               speed,
    output logic                     led_en,
    output logic [1:0]               led_colour,
    output logic [3:0]               led_onehot,
    output logic [5:0]               index,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ON,
        ST_OFF,
        ST_DONE
    } state_t;

    state_t     state;
    logic [5:0] n_total;

    logic [5:0] round_clamped;
    logic [5:0] speed_steps;
    logic [2:0] speed_code;
    logic [5:0] next_index;
    logic       last_colour;

    // Round clamp and speed code derived from the requested round count.
    always_comb begin
        round_clamped = (round > 6'(MAX_SEG)) ? 6'(MAX_SEG) : round;
        speed_steps   = round_clamped >> SPEED_SHIFT;
        speed_code    = (speed_steps > 6'd4) ? 3'd4 : speed_steps[2:0];
        next_index    = index + 6'd1;
        last_colour   = (index == (n_total - 6'd1));
    end

    // Sequencer FSM with registered outputs. The speed code is captured on
    // the IDLE->LOAD edge so it is already valid while load_speed is high,
    // which is when the timer samples it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            n_total    <= 6'd0;
            load_speed <= 1'b0;
            speed      <= 3'd0;
            led_en     <= 1'b0;
            led_colour <= 2'd0;
            led_onehot <= 4'd0;
            index      <= 6'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            load_speed <= 1'b0;
            done       <= 1'b0;
            if (abort && busy) begin
                // busy is high exactly in LOAD, ON and OFF
                state      <= ST_IDLE;
                led_en     <= 1'b0;
                led_colour <= 2'd0;
                led_onehot <= 4'd0;
                index      <= 6'd0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            if (round == 6'd0) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state      <= ST_LOAD;
                                n_total    <= round_clamped;
                                index      <= 6'd0;
                                speed      <= speed_code;
                                load_speed <= 1'b1;
                                busy       <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        // a pulse here is stale: the timer is being reloaded
                        state      <= ST_ON;
                        led_en     <= 1'b1;
                        led_colour <= segment[index];
                        led_onehot <= 4'b0001 << segment[index];
                    end
                    ST_ON: begin
                        if (pulse) begin
                            state      <= ST_OFF;
                            led_en     <= 1'b0;
                            led_colour <= 2'd0;
                            led_onehot <= 4'd0;
                        end
                    end
                    ST_OFF: begin
                        if (pulse) begin
                            if (last_colour) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state      <= ST_ON;
                                index      <= next_index;
                                led_en     <= 1'b1;
                                led_colour <= segment[next_index];
                                led_onehot <= 4'b0001 << segment[next_index];
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/playback_sequencer.md
# playback_sequencer

Sequences the "show" phase of each round. Once the main FSM starts a playback, this block steps through the first N entries of the colour segment array and presents each colour to the LED display for one timer period, followed by one dark period. It programs the variable flash timer's speed from the round number and paces itself on the timer's pulse. It sits between the FSM, the segments array, the flash timer and the LED output, and reports completion with a one-cycle done strobe.

## Interface
Parameters:
- MAX_SEG, 33: number of segment entries; the round count is clamped to this value.
- SPEED_SHIFT, 3: rounds per speed step are 2^SPEED_SHIFT (8 rounds per step).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high; dominates all other inputs
- start  in  1  single-cycle request to play; accepted only in IDLE
- abort  in  1  cancels an in-progress playback; no done is issued
- round  in  6  number of colours to play, 0..63; values above MAX_SEG are clamped to MAX_SEG
- segment  in  [32:0][1:0]  colour array; must be held stable by upstream while busy
- pulse  in  1  period tick from variable_timer
- load_speed  out  1  one-cycle strobe that reloads variable_timer
- speed  out  3  speed code to variable_timer, registered
- led_en  out  1  high while a colour is being shown
- led_colour  out  2  colour index being shown; 0 when led_en is low
- led_onehot  out  4  one-hot of led_colour when led_en is high, else 4'b0000
- index  out  6  0-based position being played
- busy  out  1  high in LOAD, ON and OFF
- done  out  1  one-cycle completion strobe

## Operation
- States: IDLE, LOAD, ON, OFF, DONE. Reset takes the FSM to IDLE.
- IDLE:
  - start with round≠0: latch n = min(round, MAX_SEG), set index=0, go to LOAD.
  - start with round=0: go directly to DONE.
- LOAD (one cycle):
  - load_speed=1.
  - speed is registered as min(n >> SPEED_SHIFT, 4): rounds 1–7→0, 8–15→1, 16–23→2, 24–31→3, 32–33→4.
  - Go to ON.
- ON: led_en=1, led_colour=segment[index], led_onehot=1<<led_colour. On pulse, go to OFF.
- OFF: LEDs are dark. On pulse:
  - if index==n-1, go to DONE;
  - otherwise index+1 and go to ON.
- DONE: done=1 for one cycle, then go to IDLE. index holds its final value.
- abort in LOAD, ON or OFF: go to IDLE on the next edge. No done is issued, and index resets to 0.
- abort in IDLE or DONE has no effect. abort and start together in IDLE: abort wins and start is dropped.
- start is ignored outside IDLE and is not queued.
- pulse is ignored in IDLE, LOAD and DONE.
- Reset values: state IDLE, load_speed 0, speed 3'b000, led_en 0, led_colour 0, led_onehot 0, index 0, busy 0, done 0.
- speed keeps its last programmed value in IDLE; only LOAD and reset change it.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Cycle counts from start sampled high at edge 0:
  - LOAD is active in cycle 1, with load_speed high for exactly that cycle.
  - ON starts in cycle 2.
- Because variable_timer reloads on load_speed, the first ON period is one full timer period.
- A pulse arriving in the same cycle as load_speed is discarded.
- Each colour takes exactly 2 pulses (ON, then OFF). Total playback is 2n pulses plus 2 cycles (LOAD and DONE).
- done asserts the cycle after the final OFF pulse is sampled. busy falls in that same cycle.
- A new start may be accepted in the cycle after done.
- Reset mid-playback: all outputs return to reset values on the next edge. No done is issued.

## Test plan
- Reset with pulse toggling -> all outputs 0 and state IDLE; start asserted during reset is ignored.
- round=3, segment[0..2]=2,0,3, pulse every 10 cycles -> load_speed at cycle 1 with speed=0. Shown sequence is led_onehot 0100, 0000, 0001, 0000, 1000, 0000. done is a single cycle after the 6th pulse; index=2 at done.
- round=20 -> speed=2 at load_speed. round=40 -> n=33, speed=4, exactly 33 ON phases and 66 pulses before done.
- start with round=0 -> done at cycle 1, no load_speed, led_en never high.
- abort during the 2nd ON phase -> IDLE next cycle, LEDs dark, index 0, no done. A second start during busy is ignored.
- pulse coincident with load_speed, and reset mid-OFF -> the pulse does not advance the FSM; reset returns all outputs to reset values with no done.
